barrel_unshifter_pipe: RTL

- Pipelined right-direction barrel shifter with a valid/ready stream on both sides.
- Accepts one word per cycle and applies right-rotate, logical right shift or arithmetic right shift by a per-word amount.
- Uses SHW mux stages, one register stage per shift-amount bit (1, 2, 4, ...), with full backpressure.
- Sits in the datapath to undo left rotations and to feed right-aligned operands downstream.

---
 rtl/barrel_unshifter_pipe.sv | 121 ++++++++++++
 1 files changed

// File: rtl/barrel_unshifter_pipe.sv
// Pipelined right barrel shifter: one register stage per shift-amount bit, each
// stage shifting by 2^k, with a valid/ready stream and full backpressure.
module barrel_unshifter_pipe #(
    parameter int WIDTH = 8,
    parameter int SHW   = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] datain,
    input  logic [SHW-1:0]   shift,
    input  logic [1:0]       mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] dataout
);

    // Handshake: a word moves across a boundary on a rising clk edge where
    // valid and ready are both high; valid never depends on ready.

    localparam logic [1:0] MODE_ROR = 2'b00;
    localparam logic [1:0] MODE_LSR = 2'b01;
    localparam logic [1:0] MODE_ASR = 2'b10;

    logic [SHW-1:0]   valid_q, valid_d;
    logic [WIDTH-1:0] data_q  [SHW];
    logic [WIDTH-1:0] data_d  [SHW];
    logic [1:0]       mode_q  [SHW];
    logic [1:0]       mode_d  [SHW];
    logic [SHW-1:0]   shamt_q [SHW];
    logic [SHW-1:0]   shamt_d [SHW];

    logic [SHW-1:0]   load;
    logic             load_acc;
    logic [1:0]       in_mode;

    // Right shift by amt when en is set; the fill comes from the word as it
    // enters this stage, so the sign bit survives every arithmetic stage.
    function automatic logic [WIDTH-1:0] stage_shift(
        input logic [WIDTH-1:0] d,
        input logic [1:0]       m,
        input logic             en,
        input int               amt
    );
        logic [WIDTH-1:0] fill_mask;
        logic [WIDTH-1:0] r;
        fill_mask = ~({WIDTH{1'b1}} >> amt);
        case (m)
            MODE_LSR: r = d >> amt;
            MODE_ASR: r = (d >> amt) | (d[WIDTH-1] ? fill_mask : '0);
            default:  r = (d >> amt) | (d << (WIDTH - amt));
        endcase
        return en ? r : d;
    endfunction

    always_comb begin
        in_mode = (mode == 2'b11) ? MODE_ROR : mode;

        // Stage k may load when it or any stage after it is empty, or the
        // consumer is taking the last word.
        load_acc = out_ready;
        load     = '0;
        for (int k = SHW - 1; k >= 0; k--) begin
            load_acc = load_acc | ~valid_q[k];
            load[k]  = load_acc;
        end

        in_ready = load[0] & ~rst;

        valid_d = valid_q;
        for (int k = 0; k < SHW; k++) begin
            data_d[k]  = data_q[k];
            mode_d[k]  = mode_q[k];
            shamt_d[k] = shamt_q[k];
        end

        if (load[0]) begin
            valid_d[0] = in_valid & ~rst;
            if (in_valid) begin
                data_d[0]  = stage_shift(datain, in_mode, shift[0], 1);
                mode_d[0]  = in_mode;
                shamt_d[0] = shift;
            end
        end

        for (int k = 1; k < SHW; k++) begin
            if (load[k]) begin
                valid_d[k] = valid_q[k-1];
                if (valid_q[k-1]) begin
                    data_d[k]  = stage_shift(data_q[k-1], mode_q[k-1],
                                             shamt_q[k-1][k], 1 << k);
                    mode_d[k]  = mode_q[k-1];
                    shamt_d[k] = shamt_q[k-1];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            for (int k = 0; k < SHW; k++) begin
                data_q[k]  <= '0;
                mode_q[k]  <= '0;
                shamt_q[k] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            for (int k = 0; k < SHW; k++) begin
                data_q[k]  <= data_d[k];
                mode_q[k]  <= mode_d[k];
                shamt_q[k] <= shamt_d[k];
            end
        end
    end

    assign out_valid = valid_q[SHW-1];
    assign dataout   = data_q[SHW-1];

endmodule
